fp_accumulator: RTL and testbench

Sequential reduction stage for neuron dot products. It accepts a stream of IEEE-754 single-precision values, one per cycle, over a valid/ready handshake and sums them with one instance of the combinational `fp_adder` (ports `a`, `b`, `sum`). On the element flagged `in_last` it presents the vector total and the element count on a registered valid/ready output. It sits directly upstream of the activation stage and downstream of the per-weight multiply stream.

---
 rtl/fp_accumulator_if.sv | 24 ++
 rtl/fp_accumulator.sv | 158 +++++++++++++++
 tb/tb_fp_accumulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp_accumulator_if.sv
// Element stream in, vector result out, between the multiply stream and the activation stage.
// Both directions use valid/ready: a beat transfers on the rising edge where valid && ready.
interface fp_accumulator_if #(
    parameter int COUNT_W = 16
);
    logic [31:0]        in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [31:0]        out_data;
    logic [COUNT_W-1:0] out_count;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_valid
    );
endinterface

// File: rtl/fp_accumulator.sv
// Sums a stream of IEEE-754 singles, one per cycle, and presents total and element count on in_last.
// fp_adder is a combinational round-to-nearest-even single-precision adder.
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d, lim;
    logic [23:0] mx, my;
    logic [4:0]  dc, lz, shl;
    logic [53:0] sh;
    logic [26:0] ya, n;
    logic [27:0] s;
    logic [9:0]  en, ef;
    logic [24:0] mr;
    logic [22:0] frac;
    logic        up, a_nan, b_nan, a_inf, b_inf;

    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] c;
        logic       found;
        c = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                c = 5'(26 - i);
                found = 1'b1;
            end
        end
        return c;
    endfunction

    always_comb begin
        // x always holds the larger magnitude, so its sign is the result sign
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {x[30:23] != 8'd0, x[22:0]};
        my = {y[30:23] != 8'd0, y[22:0]};
        d  = ex - ey;
        dc = (d > 8'd27) ? 5'd27 : d[4:0];
        sh = {my, 3'b000, 27'd0} >> dc;
        ya = {sh[53:28], sh[27] | (|sh[26:0])};
        if (x[31] == y[31]) s = {1'b0, mx, 3'b000} + {1'b0, ya};
        else                s = {1'b0, mx, 3'b000} - {1'b0, ya};
        lz  = clz27(s[26:0]);
        lim = ex - 8'd1;
        shl = 5'd0;
        if (s[27]) begin
            n  = {s[27:2], s[1] | s[0]};
            en = {2'b00, ex} + 10'd1;
        end else begin
            // never normalise below the minimum exponent; the rest stays subnormal
            shl = ({3'b000, lz} > lim) ? lim[4:0] : lz;
            n   = s[26:0] << shl;
            en  = {2'b00, ex} - {5'd0, shl};
        end
        up = n[2] & (n[1] | n[0] | n[3]);
        mr = {1'b0, n[26:3]} + {24'd0, up};
        if (mr[24]) begin
            ef = en + 10'd1; frac = mr[23:1];
        end else if (mr[23]) begin
            ef = en; frac = mr[22:0];
        end else begin
            ef = 10'd0; frac = mr[22:0];
        end
        if (ef >= 10'd255) sum = {x[31], 8'hFF, 23'd0};
        else               sum = {x[31], ef[7:0], frac};
        if (s == 28'd0) sum = {x[31] & y[31], 31'd0};
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) sum = 32'h7FC00000;
        else if (a_inf) sum = a;
        else if (b_inf) sum = b;
    end
endmodule

module fp_accumulator #(
    parameter int COUNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    fp_accumulator_if.slave  bus,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    state_t             state;
    logic [31:0]        acc, sum, nxt_acc;
    logic [COUNT_W-1:0] cnt, nxt_cnt;

    fp_adder u_add (.a(acc), .b(bus.in_data), .sum(sum));

    assign bus.in_ready = !clr && (state != HOLD);
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

    // The first element bypasses the adder so it is carried bit-exact, -0.0 included
    always_comb begin
        nxt_acc = sum;
        nxt_cnt = (cnt == {COUNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        if (state == IDLE) begin
            nxt_acc = bus.in_data;
            nxt_cnt = COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= 32'h0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 32'h0;
            bus.out_count <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (clr) begin
                        state <= IDLE;
                        acc   <= 32'h0;
                        cnt   <= '0;
                    end else if (bus.in_valid) begin
                        if (bus.in_last) begin
                            bus.out_data  <= nxt_acc;
                            bus.out_count <= nxt_cnt;
                            bus.out_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            acc   <= nxt_acc;
                            cnt   <= nxt_cnt;
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // clr is ignored here: a presented result is never withdrawn
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                        acc           <= 32'h0;
                        cnt           <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: hand-computed vector sums, handshake timing, clr and async reset.
module tb_fp_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;

    fp_accumulator_if #(.COUNT_W(16)) bus ();

    fp_accumulator #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic last);
        int  n = 0;
        bit  taken = 1'b0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!taken && n < 20) begin
            taken = bus.in_ready;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout data=%h not accepted in 20 cycles", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_data = 32'h0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_three();
        bus.out_ready = 1'b1;
        drive(32'h3F800000, 1'b0);
        drive(32'h40000000, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL three_early_valid got=%b exp=0", bus.out_valid); end
        drive(32'h40400000, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL three_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h40C00000) begin errors++; $display("FAIL three_data got=%h exp=40C00000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd3) begin errors++; $display("FAIL three_count got=%0d exp=3", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL three_hold_in_ready got=%b exp=0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL three_one_cycle got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL three_in_ready_after got=%b exp=1", bus.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL three_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_cancel_single();
        bus.out_ready = 1'b1;
        drive(32'hC0000000, 1'b0);
        drive(32'h40000000, 1'b1);
        checks++; if (bus.out_data !== 32'h00000000) begin errors++; $display("FAIL cancel_data got=%h exp=00000000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd2) begin errors++; $display("FAIL cancel_count got=%0d exp=2", bus.out_count); end
        step();
        drive(32'h40E00000, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h40E00000) begin errors++; $display("FAIL single_data got=%h exp=40E00000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.out_count); end
        step();
        // -0.0 as a single element must come out unchanged
        drive(32'h80000000, 1'b1);
        checks++; if (bus.out_data !== 32'h80000000) begin errors++; $display("FAIL negzero_data got=%h exp=80000000", bus.out_data); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(32'hC2800000, 1'b0);
        drive(32'hC2600000, 1'b1);
        // a stray element offered during HOLD must not be taken
        bus.in_data = 32'h3F800000; bus.in_valid = 1'b1; bus.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // -64.0 + -56.0 = -120.0
            checks++; if (bus.out_data !== 32'hC2F00000) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=C2F00000", i, bus.out_data); end
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_flags[%0d] got valid=%b in_ready=%b busy=%b exp 1/0/1", i, bus.out_valid, bus.in_ready, busy);
            end
            checks++; if (bus.out_count !== 16'd2) begin errors++; $display("FAIL bp_count[%0d] got=%0d exp=2", i, bus.out_count); end
            step();
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_take got=%b exp=1", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_after_take got valid=%b in_ready=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, busy);
        end
    endtask

    task automatic test_long_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            drive(32'h3F800000, (i == 9));
        end
        checks++; if (bus.out_data !== 32'h41200000) begin errors++; $display("FAIL long_data got=%h exp=41200000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd10) begin errors++; $display("FAIL long_count got=%0d exp=10", bus.out_count); end
        step();
    endtask

    task automatic test_clr();
        bus.out_ready = 1'b1;
        drive(32'h40000000, 1'b0);
        drive(32'h40000000, 1'b0);
        clr = 1'b1;
        bus.in_data = 32'h40000000; bus.in_valid = 1'b1; bus.in_last = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got=%b exp=0", bus.in_ready); end
        step();
        clr = 1'b0; bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", busy); end
        drive(32'h3F800000, 1'b1);
        checks++; if (bus.out_data !== 32'h3F800000) begin errors++; $display("FAIL clr_next_data got=%h exp=3F800000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd1) begin errors++; $display("FAIL clr_next_count got=%0d exp=1", bus.out_count); end
        step();
        // clr while a result is held leaves it in place
        bus.out_ready = 1'b0;
        drive(32'h40000000, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40000000) begin
            errors++; $display("FAIL clr_in_hold got valid=%b data=%h exp 1/40000000", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        drive(32'h40000000, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_accum got busy=%b state=%0d exp 0/0", busy, dbg_state); end
        rst = 1'b0;
        step();
        bus.out_ready = 1'b0;
        drive(32'h40400000, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_setup got=%b exp=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_count !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_hold got valid=%b data=%h count=%0d busy=%b exp 0/00000000/0/0", bus.out_valid, bus.out_data, bus.out_count, busy);
        end
        rst = 1'b0;
        step();
        bus.out_ready = 1'b1;
        drive(32'h40400000, 1'b0);
        drive(32'h40400000, 1'b1);
        checks++; if (bus.out_data !== 32'h40C00000) begin errors++; $display("FAIL rst_next_data got=%h exp=40C00000", bus.out_data); end
        checks++; if (bus.out_count !== 16'd2) begin errors++; $display("FAIL rst_next_count got=%0d exp=2", bus.out_count); end
        step();
    endtask

    initial begin
        test_reset();
        test_three();
        test_cancel_single();
        test_backpressure();
        test_long_stream();
        test_clr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
